tft_pclk_ctrl: RTL and testbench
================================

# tft_pclk_ctrl

Sequencing controller for the TFT pixel-clock generator. It owns the generator's reset and divide inputs and accepts divide changes from the wishbone register file through a strobe/ack handshake. It applies each change by resetting the generator for a fixed number of cycles, then waits for lock with a timeout and bounded retries. It reports ready/busy/error to the TFT controller and counts lock losses during operation.

## Interface
Parameters:
- RST_CYCLES, 8: cycles gen_rst is held high per (re)start; must be ≥1.
- LOCK_TIMEOUT, 1024: cycles in WAIT_LOCK before a lock attempt fails; must be ≥4.
- MAX_RETRIES, 3: failed lock attempts before FAIL; must be ≥1.
- RESET_DIVIDE, 16'd0: gen_divide value after reset.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- enable  in  1  level; 1 = run the pixel clock.
- cfg_divide  in  16  requested divide value.
- cfg_stb  in  1  one-cycle request to apply cfg_divide.
- cfg_ack  out  1  one-cycle acknowledge of cfg_stb.
- gen_rst  out  1  active-high reset to the pclk generator.
- gen_divide  out  16  divide value to the pclk generator.
- gen_lock  in  1  generator lock; asynchronous to clk.
- ready  out  1  pclk locked and running.
- busy  out  1  restart in progress.
- error  out  1  sticky; lock not achieved within MAX_RETRIES attempts.
- err_clr  in  1  one-cycle request to clear error and leave FAIL.
- relock_count  out  8  lock losses seen in RUN; saturates at 255.

## Operation
- gen_lock passes through a 2-flop synchronizer. All decisions use the synchronized value (lock_s).
- Pending register:
  - cfg_stb=1 in any state stores cfg_divide and sets pending.
  - cfg_ack=1 on the following cycle. Every strobe is acked.
  - A later strobe overwrites an unapplied value (last wins).
- Application: pending is consumed, and gen_divide loaded, on entry to RESET. In IDLE, gen_divide is loaded directly and pending is cleared.
- States:
  - IDLE: gen_rst=1. If enable=1, go to RESET with retry count = 0.
  - RESET: gen_rst=1; count RST_CYCLES cycles.
    - At the end: if pending, restart RESET and apply the new value.
    - Otherwise go to WAIT_LOCK with the timeout counter cleared.
    - enable=0 goes to IDLE.
  - WAIT_LOCK: gen_rst=0. Priority order:
    - enable=0 goes to IDLE.
    - Pending goes to RESET.
    - lock_s=1 goes to RUN.
    - Timeout (LOCK_TIMEOUT cycles) increments retry. If retry < MAX_RETRIES, go to RESET; otherwise go to FAIL.
  - RUN: gen_rst=0, ready=1. Priority order:
    - enable=0 goes to IDLE.
    - Pending goes to RESET with retry = 0.
    - lock_s=0 increments relock_count (saturating) and goes to RESET with retry = 0.
  - FAIL: gen_rst=1, error=1. err_clr=1 clears error and goes to IDLE. cfg strobes are still latched and acked here.
- Output decode:
  - busy=1 in RESET and WAIT_LOCK.
  - ready=1 only in RUN.
- All outputs are registered.

## Timing
- Reset values: state IDLE, gen_rst=1, gen_divide=RESET_DIVIDE, ready=0, busy=0, error=0, cfg_ack=0, relock_count=0, pending=0, synchronizer flops=0.
- Asserting rst forces these values immediately, including mid-RUN or mid-RESET.
- enable rises in cycle E (IDLE):
  - gen_rst stays 1 for cycles E+1 .. E+RST_CYCLES.
  - gen_rst=0 from E+RST_CYCLES+1 (WAIT_LOCK entry, cycle W).
- gen_lock steady high: lock_s=1 at W+2 and ready=1 at W+3. Minimum enable-to-ready latency is RST_CYCLES+4.
- Lock loss: relock_count increments and ready drops 3 cycles after gen_lock falls (2 sync + 1).
- cfg_stb in cycle S: cfg_ack=1 in S+1. If in RUN, ready=0 and gen_rst=1 from S+2, with the new gen_divide from S+2.
- error rises on the cycle after the MAX_RETRIES-th timeout and stays high until err_clr or rst.

## Test plan
- rst release, enable=1, gen_lock=1, defaults -> gen_rst high exactly 8 cycles, busy high during RESET/WAIT_LOCK, ready=1 at W+3, relock_count=0.
- In RUN, cfg_stb with cfg_divide=0x0010 -> cfg_ack one cycle later; ready falls; gen_divide=0x0010 and gen_rst high 8 cycles; ready returns.
- gen_lock held 0, LOCK_TIMEOUT=16, MAX_RETRIES=3 -> three RESET/WAIT_LOCK attempts, then error=1 with gen_rst=1; err_clr -> error=0 and a new attempt starts.
- In RUN, pulse gen_lock low for 1 cycle -> relock_count=1 and relock. Repeat 300 times -> relock_count=255.
- Two cfg_stb (0x0004, then 0x0020) during RESET -> two acks; RESET restarts; final gen_divide=0x0020.
- enable=0 mid-WAIT_LOCK -> IDLE with busy=0 next cycle. rst=0 mid-RUN -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/tft_pclk_ctrl.sv
// tft_pclk_ctrl: sequences reset, divide updates and lock acquisition for the TFT pixel-clock generator.
module tft_pclk_ctrl #(
  parameter int          RST_CYCLES   = 8,
  parameter int          LOCK_TIMEOUT = 1024,
  parameter int          MAX_RETRIES  = 3,
  parameter logic [15:0] RESET_DIVIDE = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] cfg_divide,
  input  logic        cfg_stb,
  output logic        cfg_ack,
  output logic        gen_rst,
  output logic [15:0] gen_divide,
  input  logic        gen_lock,
  output logic        ready,
  output logic        busy,
  output logic        error,
  input  logic        err_clr,
  output logic [7:0]  relock_count
);
  localparam int CMAX = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = $clog2(MAX_RETRIES + 1);
  typedef enum logic [2:0] {S_IDLE, S_RESET, S_WAIT, S_RUN, S_FAIL} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [1:0]    sync_q;
  logic          pend_q, pend_d, load;
  logic [15:0]   pdiv_q, pdiv_d, gen_divide_d;
  logic [7:0]    relock_d;
  logic          lock_s;
  assign lock_s = sync_q[1];
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    retry_d  = retry_q;
    relock_d = relock_count;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        load = pend_q;
        if (enable) begin
          state_d = S_RESET;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      S_RESET: begin
        if (!enable) state_d = S_IDLE;
        else if (cnt_q == CW'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          load    = pend_q;
          state_d = pend_q ? S_RESET : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable) state_d = S_IDLE;
        else if (pend_q) begin
          state_d = S_RESET;
          cnt_d   = '0;
          load    = 1'b1;
        end else if (lock_s) state_d = S_RUN;
        else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 1'b1;
          cnt_d   = '0;
          state_d = (retry_q + 1'b1 < RW'(MAX_RETRIES)) ? S_RESET : S_FAIL;
        end
      end
      S_RUN: begin
        if (!enable) state_d = S_IDLE;
        else if (pend_q || !lock_s) begin
          state_d  = S_RESET;
          cnt_d    = '0;
          retry_d  = '0;
          load     = pend_q;
          relock_d = (pend_q || relock_count == 8'hff) ? relock_count : relock_count + 8'd1;
        end
      end
      S_FAIL: state_d = err_clr ? S_IDLE : S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end
  assign pend_d       = cfg_stb | (pend_q & ~load);
  assign pdiv_d       = cfg_stb ? cfg_divide : pdiv_q;
  assign gen_divide_d = load ? pdiv_q : gen_divide;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      sync_q       <= '0;
      pend_q       <= 1'b0;
      pdiv_q       <= RESET_DIVIDE;
      gen_divide   <= RESET_DIVIDE;
      gen_rst      <= 1'b1;
      ready        <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      cfg_ack      <= 1'b0;
      relock_count <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      // lock is meaningless while the generator is held in reset, so the synchronizer restarts from 0
      sync_q       <= gen_rst ? 2'b00 : {sync_q[0], gen_lock};
      pend_q       <= pend_d;
      pdiv_q       <= pdiv_d;
      gen_divide   <= gen_divide_d;
      gen_rst      <= state_d == S_IDLE || state_d == S_RESET || state_d == S_FAIL;
      ready        <= state_d == S_RUN;
      busy         <= state_d == S_RESET || state_d == S_WAIT;
      error        <= state_d == S_FAIL;
      cfg_ack      <= cfg_stb;
      relock_count <= relock_d;
    end
  end
endmodule

// File: tb/tb_tft_pclk_ctrl.sv
// tb_tft_pclk_ctrl: directed checks of restart sequencing, cfg handshake, relock counting and retry/fail.
module tb_tft_pclk_ctrl;
  logic        clk = 1'b0, rst = 1'b0, enable = 1'b0, cfg_stb = 1'b0, gen_lock = 1'b1, err_clr = 1'b0;
  logic [15:0] cfg_divide = '0;
  logic        cfg_ack, gen_rst, ready, busy, error;
  logic [15:0] gen_divide;
  logic [7:0]  relock_count;
  int          n_chk = 0, n_fail = 0;

  tft_pclk_ctrl #(.RST_CYCLES(8), .LOCK_TIMEOUT(16), .MAX_RETRIES(3), .RESET_DIVIDE(16'd0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_divide(cfg_divide), .cfg_stb(cfg_stb),
    .cfg_ack(cfg_ack), .gen_rst(gen_rst), .gen_divide(gen_divide), .gen_lock(gen_lock),
    .ready(ready), .busy(busy), .error(error), .err_clr(err_clr), .relock_count(relock_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Called in the first RESET cycle; ends in the first RUN cycle.
  task automatic expect_bringup(input string tag);
    for (int k = 0; k < 12; k++) begin
      check_eq({tag, "_gen_rst"}, 16'(gen_rst), 16'(k < 8));
      check_eq({tag, "_busy"}, 16'(busy), 16'(k < 11));
      check_eq({tag, "_ready"}, 16'(ready), 16'(k == 11));
      if (k < 11) step();
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      step();
      n++;
    end
    if (!ready) check_eq({tag, "_timeout"}, 16'(ready), 16'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_gen_rst"}, 16'(gen_rst), 16'd1);
    check_eq({tag, "_gen_divide"}, gen_divide, 16'd0);
    check_eq({tag, "_ready"}, 16'(ready), 16'd0);
    check_eq({tag, "_busy"}, 16'(busy), 16'd0);
    check_eq({tag, "_error"}, 16'(error), 16'd0);
    check_eq({tag, "_cfg_ack"}, 16'(cfg_ack), 16'd0);
    check_eq({tag, "_relock"}, 16'(relock_count), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    check_reset_vals("por");
    rst = 1'b1;
    step(2);
    // Bring-up: enable rises in cycle E
    enable = 1'b1;
    step();
    expect_bringup("bringup");
    check_eq("bringup_relock", 16'(relock_count), 16'd0);
    // Divide change while running
    cfg_divide = 16'h0010;
    cfg_stb = 1'b1;
    step();
    cfg_stb = 1'b0;
    check_eq("cfg_ack_s1", 16'(cfg_ack), 16'd1);
    check_eq("cfg_ready_s1", 16'(ready), 16'd1);
    step();
    check_eq("cfg_ack_s2", 16'(cfg_ack), 16'd0);
    check_eq("cfg_divide_s2", gen_divide, 16'h0010);
    expect_bringup("cfg");
    // Single-cycle lock loss
    gen_lock = 1'b0;
    step();
    gen_lock = 1'b1;
    step();
    check_eq("loss_ready_l2", 16'(ready), 16'd1);
    check_eq("loss_relock_l2", 16'(relock_count), 16'd0);
    step();
    check_eq("loss_relock_l3", 16'(relock_count), 16'd1);
    expect_bringup("loss");
    for (int i = 0; i < 299; i++) begin
      gen_lock = 1'b0;
      step();
      gen_lock = 1'b1;
      step(2);
      wait_ready("relock_loop", 40);
    end
    check_eq("relock_sat", 16'(relock_count), 16'd255);
    // Two strobes during RESET: last wins, RESET restarts
    enable = 1'b0;
    step();
    check_eq("dis_busy", 16'(busy), 16'd0);
    check_eq("dis_gen_rst", 16'(gen_rst), 16'd1);
    enable = 1'b1;
    step(2);
    cfg_divide = 16'h0004;
    cfg_stb = 1'b1;
    step();
    cfg_stb = 1'b0;
    check_eq("dbl_ack1", 16'(cfg_ack), 16'd1);
    step();
    check_eq("dbl_ack1_off", 16'(cfg_ack), 16'd0);
    cfg_divide = 16'h0020;
    cfg_stb = 1'b1;
    step();
    cfg_stb = 1'b0;
    check_eq("dbl_ack2", 16'(cfg_ack), 16'd1);
    check_eq("dbl_div_hold", gen_divide, 16'h0010);
    step(3);
    check_eq("dbl_last_reset", 16'(gen_rst), 16'd1);
    step();
    check_eq("dbl_div_final", gen_divide, 16'h0020);
    expect_bringup("dbl");
    // Lock never comes: three attempts then FAIL
    gen_lock = 1'b0;
    step(3);
    check_eq("to_r0_gen_rst", 16'(gen_rst), 16'd1);
    check_eq("to_r0_relock", 16'(relock_count), 16'd255);
    step(8);
    check_eq("to_w1_gen_rst", 16'(gen_rst), 16'd0);
    step(16);
    check_eq("to_r2_gen_rst", 16'(gen_rst), 16'd1);
    check_eq("to_r2_busy", 16'(busy), 16'd1);
    step(47);
    check_eq("to_pre_error", 16'(error), 16'd0);
    check_eq("to_pre_busy", 16'(busy), 16'd1);
    step();
    check_eq("to_error", 16'(error), 16'd1);
    check_eq("to_fail_gen_rst", 16'(gen_rst), 16'd1);
    check_eq("to_fail_busy", 16'(busy), 16'd0);
    step(5);
    check_eq("to_error_sticky", 16'(error), 16'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("clr_error", 16'(error), 16'd0);
    check_eq("clr_busy", 16'(busy), 16'd0);
    step();
    check_eq("clr_restart_busy", 16'(busy), 16'd1);
    gen_lock = 1'b1;
    wait_ready("clr", 40);
    check_eq("clr_ready", 16'(ready), 16'd1);
    // enable drop in WAIT_LOCK
    enable = 1'b0;
    step();
    enable = 1'b1;
    step(9);
    check_eq("wl_gen_rst", 16'(gen_rst), 16'd0);
    check_eq("wl_busy", 16'(busy), 16'd1);
    enable = 1'b0;
    step();
    check_eq("wl_idle_busy", 16'(busy), 16'd0);
    check_eq("wl_idle_gen_rst", 16'(gen_rst), 16'd1);
    // Asynchronous reset mid-RUN
    enable = 1'b1;
    wait_ready("pre_rst", 40);
    check_eq("pre_rst_divide", gen_divide, 16'h0020);
    rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
